// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage of the multi-cycle RISC-V core.
//   fetch_state_e       : fetch FSM state encoding
//   INSTR_WIDTH_DEFAULT : default instruction word width
//   NOP_INSTR           : canonical NOP (addi x0, x0, 0), used by benches and
//                         for future stall insertion
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_WIDTH_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR           = 32'h00000013;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus used by the fetch stage.
//   mem_req    : read request (master -> slave)
//   mem_addr   : word index to read (master -> slave)
//   mem_ready  : request accepted this cycle (slave -> master)
//   mem_rvalid : read data valid (slave -> master)
//   mem_rdata  : read data (slave -> master)
interface instruction_fetch_unit_if
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = INSTR_WIDTH_DEFAULT
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_timeout_counter.sv
// Saturating cycle counter that flags when a bounded wait has run out.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart counting from zero (priority over enable)
//   enable   : count this cycle
//   expired  : count has reached LIMIT-1
// Intended for reuse by the data-memory stage.
module fetch_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == CNT_W'(LIMIT - 1));

    // Holds at LIMIT-1 so the flag stays asserted until cleared.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads one instruction word at instruction_ptr over a
// req/ready + rvalid handshake, latches it into the instruction register and
// pulses pc_advance/fetch_done once per successful fetch.
//   clk, rst        : clock, synchronous active-high reset
//   fetch_start     : start a fetch (accepted only when idle)
//   flush           : abort the fetch in flight, invalidate IR, clear fault
//   instruction_ptr : current PC (word index)
//   mem             : instruction-memory bus (master side)
//   instr_reg       : instruction register
//   ir_valid        : instr_reg holds a valid instruction
//   pc_advance      : one-cycle pulse, PC increments
//   fetch_done      : one-cycle pulse coincident with pc_advance
//   busy            : not idle
//   fault           : sticky fetch-timeout flag
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 6,
    parameter int unsigned INSTR_WIDTH    = INSTR_WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_start,
    input  logic                         flush,
    input  logic [(2**ADDRESS_SIZE)-1:0] instruction_ptr,
    instruction_fetch_unit_if.master     mem,
    output logic [INSTR_WIDTH-1:0]       instr_reg,
    output logic                         ir_valid,
    output logic                         pc_advance,
    output logic                         fetch_done,
    output logic                         busy,
    output logic                         fault
);
    localparam int unsigned PTR_W = 2**ADDRESS_SIZE;

    fetch_state_e           state_q,      state_d;
    logic                   mem_req_q,    mem_req_d;
    logic [PTR_W-1:0]       mem_addr_q,   mem_addr_d;
    logic [INSTR_WIDTH-1:0] instr_reg_q,  instr_reg_d;
    logic                   ir_valid_q,   ir_valid_d;
    logic                   pc_advance_q, pc_advance_d;
    logic                   fetch_done_q, fetch_done_d;
    logic                   busy_q,       busy_d;
    logic                   fault_q,      fault_d;

    logic complete;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        instr_reg_d = instr_reg_q;
        ir_valid_d  = ir_valid_q;
        fault_d     = fault_q;
        complete    = 1'b0;

        unique case (state_q)
            FETCH_IDLE: begin
                if (fetch_start && !flush) begin
                    state_d    = FETCH_REQ;
                    mem_addr_d = instruction_ptr;
                    ir_valid_d = 1'b0;
                end
            end
            FETCH_REQ: begin
                if (mem.mem_ready && mem.mem_rvalid) begin
                    complete = 1'b1;
                    state_d  = FETCH_IDLE;
                end else if (timer_expired) begin
                    // An accepted request still owes a response: drain it.
                    fault_d = 1'b1;
                    state_d = mem.mem_ready ? FETCH_DRAIN : FETCH_IDLE;
                end else if (mem.mem_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (mem.mem_rvalid) begin
                    complete = 1'b1;
                    state_d  = FETCH_IDLE;
                end else if (timer_expired) begin
                    fault_d = 1'b1;
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (mem.mem_rvalid) begin
                    state_d = FETCH_IDLE;
                end else if (timer_expired) begin
                    fault_d = 1'b1;
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        // Flush overrides the decisions above. A response arriving in the
        // flush cycle is consumed here, so only a still-outstanding request
        // needs the DRAIN state.
        if (flush) begin
            complete   = 1'b0;
            ir_valid_d = 1'b0;
            fault_d    = 1'b0;
            unique case (state_q)
                FETCH_IDLE:  state_d = FETCH_IDLE;
                FETCH_REQ:   state_d = (mem.mem_ready && !mem.mem_rvalid) ? FETCH_DRAIN : FETCH_IDLE;
                FETCH_WAIT:  state_d = mem.mem_rvalid ? FETCH_IDLE : FETCH_DRAIN;
                FETCH_DRAIN: state_d = (mem.mem_rvalid || timer_expired) ? FETCH_IDLE : FETCH_DRAIN;
                default:     state_d = FETCH_IDLE;
            endcase
        end

        if (complete) begin
            instr_reg_d = mem.mem_rdata;
            ir_valid_d  = 1'b1;
        end

        pc_advance_d = complete;
        fetch_done_d = complete;
        mem_req_d    = (state_d == FETCH_REQ);
        busy_d       = (state_d != FETCH_IDLE);

        // Each bounded wait (request phase, drain phase) gets its own budget.
        timer_clear  = ((state_d == FETCH_REQ)   && (state_q != FETCH_REQ)) ||
                       ((state_d == FETCH_DRAIN) && (state_q != FETCH_DRAIN));
        timer_enable = (state_q != FETCH_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            instr_reg_q  <= '0;
            ir_valid_q   <= 1'b0;
            pc_advance_q <= 1'b0;
            fetch_done_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            instr_reg_q  <= instr_reg_d;
            ir_valid_q   <= ir_valid_d;
            pc_advance_q <= pc_advance_d;
            fetch_done_q <= fetch_done_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign instr_reg    = instr_reg_q;
    assign ir_valid     = ir_valid_q;
    assign pc_advance   = pc_advance_q;
    assign fetch_done   = fetch_done_q;
    assign busy         = busy_q;
    assign fault        = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. Each fetch is described by
// its memory timing (cycles to ready, cycles from ready to rvalid) and an
// optional flush cycle; the expected cycle-by-cycle busy/mem_req/pc_advance
// and the final IR/valid/fault are derived arithmetically from those numbers.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int unsigned ADDRESS_SIZE   = 6;
    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned PTR_W          = 2**ADDRESS_SIZE;
    localparam int          TO             = TIMEOUT_CYCLES;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   fetch_start;
    logic                   flush;
    logic [PTR_W-1:0]       instruction_ptr;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic                   ir_valid;
    logic                   pc_advance;
    logic                   fetch_done;
    logic                   busy;
    logic                   fault;

    instruction_fetch_unit_if #(
        .ADDR_WIDTH (PTR_W),
        .DATA_WIDTH (INSTR_WIDTH)
    ) mem_if ();

    instruction_fetch_unit #(
        .ADDRESS_SIZE   (ADDRESS_SIZE),
        .INSTR_WIDTH    (INSTR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_start     (fetch_start),
        .flush           (flush),
        .instruction_ptr (instruction_ptr),
        .mem             (mem_if),
        .instr_reg       (instr_reg),
        .ir_valid        (ir_valid),
        .pc_advance      (pc_advance),
        .fetch_done      (fetch_done),
        .busy            (busy),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [INSTR_WIDTH-1:0] model_ir;
    logic                   model_valid;
    logic                   model_fault;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        fetch_start          = 1'b0;
        flush                = 1'b0;
        mem_if.mem_ready     = 1'b0;
        mem_if.mem_rvalid    = 1'b0;
        mem_if.mem_rdata     = NOP_INSTR;
    endtask

    // One fetch. Cycle 0 is the first cycle after fetch_start is sampled.
    // The memory accepts in cycle rdy_dly (only if mem_req is high then) and
    // returns data rv_dly cycles later. flush_at < 0 means no flush.
    task automatic run_fetch(input logic [PTR_W-1:0] ptr, input logic [31:0] data,
                             input int rdy_dly, input int rv_dly,
                             input int flush_at, input bit hold_start);
        int  c;
        int  e;
        int  a;
        bit  success;
        bit  accepted;
        c = rdy_dly + rv_dly;
        a = (rdy_dly < TO - 1) ? rdy_dly : TO - 1;
        if (flush_at >= 0) begin
            if (flush_at < a) a = flush_at;
            success = 1'b0;
            e = (rdy_dly <= flush_at && flush_at < c) ? c + 1 : flush_at + 1;
        end else if (c <= TO - 1) begin
            success = 1'b1;
            e = c + 1;
        end else begin
            success = 1'b0;
            e = (rdy_dly <= TO - 1) ? c + 1 : TO;
        end

        instruction_ptr = ptr;
        fetch_start     = 1'b1;
        flush           = 1'b0;
        @(posedge clk); #1;
        accepted = 1'b0;
        for (int k = 0; k <= e + 1; k++) begin
            check_val("busy",       busy,              k < e);
            check_val("mem_req",    mem_if.mem_req,    k <= a);
            check_val("pc_advance", pc_advance,        success && k == e);
            check_val("fetch_done", fetch_done,        success && k == e);
            if (k == 0) check_val("mem_addr", mem_if.mem_addr, ptr);
            if (k == e) begin
                if (success) begin
                    model_ir    = data;
                    model_valid = 1'b1;
                end else begin
                    model_valid = 1'b0;
                    if (flush_at >= 0) model_fault = 1'b0;
                    else               model_fault = 1'b1;
                end
                check_val("instr_reg", instr_reg, model_ir);
                check_val("ir_valid",  ir_valid,  model_valid);
                check_val("fault",     fault,     model_fault);
            end
            fetch_start      = hold_start && (k < e);
            flush            = (k == flush_at);
            mem_if.mem_ready = mem_if.mem_req && (k == rdy_dly);
            if (mem_if.mem_ready) accepted = 1'b1;
            mem_if.mem_rvalid = accepted && (k == c);
            mem_if.mem_rdata  = mem_if.mem_rvalid ? data : $urandom();
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd;
        int rv;
        int fl;
        int c;
        idle_inputs();
        rst             = 1'b1;
        instruction_ptr = '0;
        model_ir        = '0;
        model_valid     = 1'b0;
        model_fault     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check_val("rst_mem_req",    mem_if.mem_req,  0);
        check_val("rst_mem_addr",   mem_if.mem_addr, 0);
        check_val("rst_instr_reg",  instr_reg,       0);
        check_val("rst_ir_valid",   ir_valid,        0);
        check_val("rst_pc_advance", pc_advance,      0);
        check_val("rst_fetch_done", fetch_done,      0);
        check_val("rst_busy",       busy,            0);
        check_val("rst_fault",      fault,           0);

        // Zero-wait, split response, timeout without acceptance.
        run_fetch(64'd5, 32'h00500093, 0, 0, -1, 1'b0);
        run_fetch(64'd9, 32'h002081B3, 2, 3, -1, 1'b0);
        run_fetch(64'd3, 32'h11111111, 20, 0, -1, 1'b0);

        // Flush in IDLE together with fetch_start: no fetch, fault cleared.
        fetch_start = 1'b1;
        flush       = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        model_valid = 1'b0;
        model_fault = 1'b0;
        check_val("idle_flush_busy",  busy,      0);
        check_val("idle_flush_fault", fault,     model_fault);
        check_val("idle_flush_valid", ir_valid,  model_valid);
        check_val("idle_flush_ir",    instr_reg, model_ir);

        // Flush in WAIT; late DEADBEEF must be discarded.
        run_fetch(64'd4, 32'hDEADBEEF, 0, 3, 1, 1'b0);

        // Timeout after acceptance: response arrives late and is drained.
        run_fetch(64'd6, 32'h22222222, 5, 15, -1, 1'b0);

        // Reset while waiting for rvalid.
        instruction_ptr = 64'd7;
        fetch_start     = 1'b1;
        @(posedge clk); #1;
        fetch_start      = 1'b0;
        mem_if.mem_ready = mem_if.mem_req;
        @(posedge clk); #1;
        mem_if.mem_ready = 1'b0;
        rst              = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        model_ir    = '0;
        model_valid = 1'b0;
        model_fault = 1'b0;
        check_val("midrst_busy",     busy,            0);
        check_val("midrst_mem_req",  mem_if.mem_req,  0);
        check_val("midrst_mem_addr", mem_if.mem_addr, 0);
        check_val("midrst_ir",       instr_reg,       0);
        check_val("midrst_valid",    ir_valid,        0);
        check_val("midrst_fault",    fault,           0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        idle_inputs();
        check_val("late_rvalid_ir",    instr_reg,  0);
        check_val("late_rvalid_valid", ir_valid,   0);
        check_val("late_rvalid_pcadv", pc_advance, 0);
        check_val("late_rvalid_busy",  busy,       0);
        run_fetch(64'd8, 32'h00A00113, 1, 0, -1, 1'b0);

        // fetch_start held through three fetches.
        for (int i = 0; i < 3; i++) begin
            run_fetch(PTR_W'(i), $urandom(), i, 1, -1, 1'b1);
        end

        // Randomized fetches.
        for (int n = 0; n < 80; n++) begin
            rd = $urandom_range(0, 20);
            rv = $urandom_range(0, 8);
            c  = rd + rv;
            fl = -1;
            if ($urandom_range(0, 3) == 0 && c <= TO - 1) fl = $urandom_range(0, c);
            run_fetch({$urandom(), $urandom()}, $urandom(), rd, rv, fl, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
